// File: rtl/ahb5_excl_atomic_master.sv
// AHB5 master performing atomic read-modify-write (fetch-add, swap, CAS) as an
// exclusive read followed by an exclusive write, retried while HEXOKAY is low.
module ahb5_excl_atomic_master #(
  parameter int         AWIDTH    = 12,
  parameter logic [3:0] MASTER_ID = 4'h1,
  parameter int         MAX_RETRY = 15
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [31:0]       cmd_cmp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_status,
  output logic [7:0]        rsp_retries,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic              HEXCL,
  output logic [3:0]        HMASTER,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [31:0]       HRDATA,
  input  logic              HEXOKAY
);

  typedef enum logic [2:0] {IDLE, RA, RD, WA, WD, RSP} state_t;

  localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRY);
  localparam logic [AWIDTH-1:0] WORD_MASK   = {{(AWIDTH-2){1'b1}}, 2'b00};
  localparam logic [1:0]        OP_ADD = 2'b00;
  localparam logic [1:0]        OP_CAS = 2'b10;
  localparam logic [1:0]        ST_OK = 2'b00, ST_CAS = 2'b01, ST_EXH = 2'b10, ST_ERR = 2'b11;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg;
  logic [AWIDTH-1:0] addr_reg;
  logic [31:0]       wdata_reg, cmp_reg, old_reg, new_reg;
  logic [1:0]        status_reg;
  logic [7:0]        retry_reg;
  logic [31:0]       computed_new;
  logic              cas_miss, read_fail;

  assign HSIZE       = 3'b010;
  assign HMASTER     = MASTER_ID;
  assign rsp_data    = old_reg;
  assign rsp_status  = status_reg;
  assign rsp_retries = retry_reg;

  // New value is derived from the word being returned in the read data phase.
  assign computed_new = (op_reg == OP_ADD) ? (HRDATA + wdata_reg) : wdata_reg;
  assign cas_miss     = (op_reg == OP_CAS) && (HRDATA != cmp_reg);
  assign read_fail    = HRESP || !HEXOKAY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    HTRANS     = 2'b00;
    HWRITE     = 1'b0;
    HEXCL      = 1'b0;
    HADDR      = '0;
    HWDATA     = '0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = RA;
      end
      RA: begin
        HTRANS = 2'b10;
        HEXCL  = 1'b1;
        HADDR  = addr_reg;
        if (HREADY) state_next = RD;
      end
      RD: begin
        if (HREADY) state_next = (read_fail || cas_miss) ? RSP : WA;
      end
      WA: begin
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HEXCL  = 1'b1;
        HADDR  = addr_reg;
        if (HREADY) state_next = WD;
      end
      WD: begin
        HWDATA = new_reg;
        if (HREADY) begin
          state_next = (HRESP || HEXOKAY || retry_reg == RETRY_LIMIT) ? RSP : RA;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      op_reg     <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      cmp_reg    <= '0;
      old_reg    <= '0;
      new_reg    <= '0;
      status_reg <= ST_OK;
      retry_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            op_reg     <= cmd_op;
            addr_reg   <= cmd_addr & WORD_MASK;
            wdata_reg  <= cmd_wdata;
            cmp_reg    <= cmd_cmp;
            status_reg <= ST_OK;
            retry_reg  <= '0;
          end
        end
        RD: begin
          if (HREADY) begin
            // A slave without exclusive support is reported like a bus error.
            if (read_fail) begin
              status_reg <= ST_ERR;
              old_reg    <= '0;
            end else begin
              old_reg <= HRDATA;
              new_reg <= computed_new;
              if (cas_miss) status_reg <= ST_CAS;
            end
          end
        end
        WD: begin
          if (HREADY) begin
            if (HRESP)                        status_reg <= ST_ERR;
            else if (HEXOKAY)                 status_reg <= ST_OK;
            else if (retry_reg == RETRY_LIMIT) status_reg <= ST_EXH;
            else                              retry_reg  <= retry_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb5_excl_atomic_master.sv
// Directed bench: AHB slave with exclusive monitor, backdoor writes for a second
// master, and per-scenario tasks with hand-computed expectations.
module tb_ahb5_excl_atomic_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]  cmd_op, rsp_status, HTRANS;
  logic [11:0] cmd_addr, HADDR;
  logic [31:0] cmd_wdata, cmd_cmp, rsp_data, HWDATA, HRDATA;
  logic [7:0]  rsp_retries;
  logic        HWRITE, HEXCL, HREADY, HRESP, HEXOKAY;
  logic [2:0]  HSIZE;
  logic [3:0]  HMASTER;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb5_excl_atomic_master #(.AWIDTH(12), .MASTER_ID(4'h1), .MAX_RETRY(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_cmp(cmd_cmp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_retries(rsp_retries),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HEXCL(HEXCL),
    .HMASTER(HMASTER), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .HEXOKAY(HEXOKAY)
  );

  // Slave model: word memory plus a single-entry exclusive monitor.
  logic [31:0] mem [0:1023];
  logic        dp_active = 1'b0, dp_write = 1'b0, dp_excl = 1'b0, excl_valid = 1'b0;
  logic [9:0]  dp_idx = '0, excl_idx = '0;
  logic        tb_hready, force_fail, err_read, intrude;
  logic [9:0]  intr_idx;
  logic [31:0] intr_val;
  int          wr_attempts = 0;

  assign HREADY  = tb_hready;
  assign HRDATA  = mem[dp_idx];
  assign HRESP   = dp_active && !dp_write && err_read;
  assign HEXOKAY = !dp_active ? 1'b0 :
                   (dp_write ? (dp_excl && excl_valid && excl_idx == dp_idx && !force_fail) : 1'b1);

  always @(posedge HCLK) begin
    if (intrude) begin
      mem[intr_idx] <= intr_val;
      if (intr_idx[9:2] == excl_idx[9:2]) excl_valid <= 1'b0;
    end
    if (HRESET) begin
      dp_active  <= 1'b0;
      excl_valid <= 1'b0;
    end else if (HREADY) begin
      if (dp_active && dp_write) begin
        if (!dp_excl || HEXOKAY) mem[dp_idx] <= HWDATA;
        excl_valid <= 1'b0;
      end else if (dp_active && dp_excl && !HRESP) begin
        excl_valid <= 1'b1;
        excl_idx   <= dp_idx;
      end
      dp_active <= (HTRANS == 2'b10);
      dp_idx    <= HADDR[11:2];
      dp_write  <= HWRITE;
      dp_excl   <= HEXCL;
      if (HTRANS == 2'b10 && HWRITE) wr_attempts <= wr_attempts + 1;
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    intr_idx = idx; intr_val = val; intrude = 1'b1;
    step();
    intrude = 1'b0;
  endtask

  // Runs one command; cycle 0 is the handshake cycle, lat is the cycle rsp_valid is seen.
  task automatic run_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] cmp, input int intr_cyc, input logic [9:0] iidx,
                         input logic [31:0] ival, input int stall_from, input int stall_n,
                         output int lat, output logic [31:0] data, output logic [1:0] st,
                         output logic [7:0] rt, output int writes, output int rd_cycles,
                         output logic ready_seen);
    int w0;
    int cyc;
    w0 = wr_attempts;
    rd_cycles = 0;
    ready_seen = 1'b0;
    intr_idx = iidx; intr_val = ival;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_cmp = cmp;
    step();
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      if (HTRANS == 2'b10 && !HWRITE && HADDR == (addr & 12'hFFC)) rd_cycles++;
      if (cmd_ready) ready_seen = 1'b1;
      intrude   = (cyc == intr_cyc);
      tb_hready = !(cyc >= stall_from && cyc < stall_from + stall_n);
      step();
      cyc++;
    end
    intrude = 1'b0;
    tb_hready = 1'b1;
    checks++; if (!rsp_valid) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, cyc); end
    lat = cyc; data = rsp_data; st = rsp_status; rt = rsp_retries;
    writes = wr_attempts - w0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  int lat, writes, rdc;
  logic [31:0] data;
  logic [1:0]  st;
  logic [7:0]  rt;
  logic        rs;

  task automatic test_reset();
    HRESET = 1'b1;
    step(); step();
    HRESET = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_handshake: cmd_ready=%0b rsp_valid=%0b, required 1/0", cmd_ready, rsp_valid); end
    checks++; if (rsp_data !== 32'h0 || rsp_status !== 2'b00 || rsp_retries !== 8'h0) begin errors++; $display("FAIL reset_rsp: data=%0h status=%0h retries=%0h, required 0/0/0", rsp_data, rsp_status, rsp_retries); end
    checks++; if (HTRANS !== 2'b00 || HWRITE !== 1'b0 || HEXCL !== 1'b0) begin errors++; $display("FAIL reset_ctrl: htrans=%0h hwrite=%0b hexcl=%0b, required 0/0/0", HTRANS, HWRITE, HEXCL); end
    checks++; if (HADDR !== 12'h0 || HWDATA !== 32'h0) begin errors++; $display("FAIL reset_bus: haddr=%0h hwdata=%0h, required 0/0", HADDR, HWDATA); end
    checks++; if (HSIZE !== 3'b010 || HMASTER !== 4'h1) begin errors++; $display("FAIL const_outputs: hsize=%0h hmaster=%0h, required 2/1", HSIZE, HMASTER); end
  endtask

  task automatic test_fetch_add();
    preload(10'h040, 32'd5);
    run_cmd(2'b00, 12'h100, 32'd3, 32'd0, -1, 10'h0, 32'h0, 0, 0, lat, data, st, rt, writes, rdc, rs);
    $display("fetch_add: lat=%0d data=%0h status=%0h retries=%0d writes=%0d mem=%0h", lat, data, st, rt, writes, mem[10'h040]);
    checks++; if (lat !== 5) begin errors++; $display("FAIL fa_latency: got %0d, required 5", lat); end
    checks++; if (data !== 32'd5 || st !== 2'b00 || rt !== 8'd0) begin errors++; $display("FAIL fa_rsp: data=%0h status=%0h retries=%0d, required 5/0/0", data, st, rt); end
    checks++; if (mem[10'h040] !== 32'd8 || writes !== 1) begin errors++; $display("FAIL fa_mem: mem=%0h writes=%0d, required 8/1", mem[10'h040], writes); end
    checks++; if (rdc !== 1 || rs !== 1'b0) begin errors++; $display("FAIL fa_bus: read_addr_cycles=%0d cmd_ready_busy=%0b, required 1/0", rdc, rs); end
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL fa_consume: rsp_valid=%0b cmd_ready=%0b, required 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_cas();
    preload(10'h041, 32'hA);
    run_cmd(2'b10, 12'h104, 32'hC, 32'hB, -1, 10'h0, 32'h0, 0, 0, lat, data, st, rt, writes, rdc, rs);
    $display("cas_miss: lat=%0d data=%0h status=%0h writes=%0d mem=%0h", lat, data, st, writes, mem[10'h041]);
    checks++; if (st !== 2'b01 || data !== 32'hA) begin errors++; $display("FAIL cas_miss_rsp: status=%0h data=%0h, required 1/a", st, data); end
    checks++; if (writes !== 0 || mem[10'h041] !== 32'hA || lat !== 3) begin errors++; $display("FAIL cas_miss_bus: writes=%0d mem=%0h lat=%0d, required 0/a/3", writes, mem[10'h041], lat); end
    run_cmd(2'b10, 12'h104, 32'hC, 32'hA, -1, 10'h0, 32'h0, 0, 0, lat, data, st, rt, writes, rdc, rs);
    $display("cas_hit: lat=%0d data=%0h status=%0h writes=%0d mem=%0h", lat, data, st, writes, mem[10'h041]);
    checks++; if (st !== 2'b00 || data !== 32'hA || mem[10'h041] !== 32'hC || writes !== 1) begin errors++; $display("FAIL cas_hit: status=%0h data=%0h mem=%0h writes=%0d, required 0/a/c/1", st, data, mem[10'h041], writes); end
  endtask

  task automatic test_retry_collision();
    preload(10'h042, 32'd10);
    run_cmd(2'b00, 12'h108, 32'd1, 32'd0, 3, 10'h042, 32'd20, 0, 0, lat, data, st, rt, writes, rdc, rs);
    $display("collision: lat=%0d data=%0h status=%0h retries=%0d writes=%0d mem=%0h", lat, data, st, rt, writes, mem[10'h042]);
    checks++; if (rt !== 8'd1 || st !== 2'b00 || data !== 32'd20) begin errors++; $display("FAIL coll_rsp: retries=%0d status=%0h data=%0h, required 1/0/14", rt, st, data); end
    checks++; if (mem[10'h042] !== 32'd21 || writes !== 2 || rdc !== 2) begin errors++; $display("FAIL coll_bus: mem=%0h writes=%0d reads=%0d, required 15/2/2", mem[10'h042], writes, rdc); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL coll_latency: got %0d, required 9", lat); end
  endtask

  task automatic test_retry_exhaust();
    preload(10'h044, 32'd7);
    force_fail = 1'b1;
    run_cmd(2'b01, 12'h110, 32'd9, 32'd0, -1, 10'h0, 32'h0, 0, 0, lat, data, st, rt, writes, rdc, rs);
    force_fail = 1'b0;
    $display("exhaust: lat=%0d data=%0h status=%0h retries=%0d writes=%0d mem=%0h", lat, data, st, rt, writes, mem[10'h044]);
    checks++; if (st !== 2'b10 || rt !== 8'd3 || data !== 32'd7) begin errors++; $display("FAIL exh_rsp: status=%0h retries=%0d data=%0h, required 2/3/7", st, rt, data); end
    checks++; if (writes !== 4 || mem[10'h044] !== 32'd7 || lat !== 17) begin errors++; $display("FAIL exh_bus: writes=%0d mem=%0h lat=%0d, required 4/7/17", writes, mem[10'h044], lat); end
  endtask

  task automatic test_bus_error();
    preload(10'h045, 32'h77);
    err_read = 1'b1;
    run_cmd(2'b00, 12'h114, 32'd1, 32'd0, -1, 10'h0, 32'h0, 0, 0, lat, data, st, rt, writes, rdc, rs);
    err_read = 1'b0;
    $display("bus_error: lat=%0d data=%0h status=%0h writes=%0d mem=%0h", lat, data, st, writes, mem[10'h045]);
    checks++; if (st !== 2'b11 || data !== 32'h0) begin errors++; $display("FAIL err_rsp: status=%0h data=%0h, required 3/0", st, data); end
    checks++; if (writes !== 0 || mem[10'h045] !== 32'h77 || lat !== 3) begin errors++; $display("FAIL err_bus: writes=%0d mem=%0h lat=%0d, required 0/77/3", writes, mem[10'h045], lat); end
  endtask

  task automatic test_wait_states();
    preload(10'h046, 32'd100);
    run_cmd(2'b00, 12'h118, 32'd28, 32'd0, -1, 10'h0, 32'h0, 1, 2, lat, data, st, rt, writes, rdc, rs);
    $display("wait_states: lat=%0d data=%0h status=%0h read_addr_cycles=%0d mem=%0h", lat, data, st, rdc, mem[10'h046]);
    checks++; if (lat !== 7 || rdc !== 3) begin errors++; $display("FAIL ws_timing: lat=%0d read_addr_cycles=%0d, required 7/3", lat, rdc); end
    checks++; if (data !== 32'd100 || st !== 2'b00 || mem[10'h046] !== 32'd128) begin errors++; $display("FAIL ws_result: data=%0h status=%0h mem=%0h, required 64/0/80", data, st, mem[10'h046]); end
  endtask

  task automatic test_reset_mid_op();
    logic quiet;
    preload(10'h047, 32'h33);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 12'h11C; cmd_wdata = 32'h5A; cmd_cmp = 32'h0;
    step();
    cmd_valid = 1'b0;
    step(); step();
    checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1) begin errors++; $display("FAIL mid_in_wa: htrans=%0h hwrite=%0b, required 2/1", HTRANS, HWRITE); end
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    $display("reset_mid_op: htrans=%0h cmd_ready=%0b rsp_valid=%0b", HTRANS, cmd_ready, rsp_valid);
    checks++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_after_reset: htrans=%0h cmd_ready=%0b rsp_valid=%0b, required 0/1/0", HTRANS, cmd_ready, rsp_valid); end
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid || HTRANS != 2'b00) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1 || mem[10'h047] !== 32'h33) begin errors++; $display("FAIL mid_abandon: quiet=%0b mem=%0h, required 1/33", quiet, mem[10'h047]); end
    preload(10'h043, 32'h44);
    run_cmd(2'b01, 12'h10E, 32'h99, 32'h0, -1, 10'h0, 32'h0, 0, 0, lat, data, st, rt, writes, rdc, rs);
    $display("swap_after_reset: lat=%0d data=%0h status=%0h mem=%0h", lat, data, st, mem[10'h043]);
    checks++; if (lat !== 5 || data !== 32'h44 || st !== 2'b00) begin errors++; $display("FAIL swap_rsp: lat=%0d data=%0h status=%0h, required 5/44/0", lat, data, st); end
    checks++; if (mem[10'h043] !== 32'h99 || rdc !== 1) begin errors++; $display("FAIL swap_mem: mem=%0h read_addr_cycles=%0d, required 99/1", mem[10'h043], rdc); end
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0; cmd_cmp = '0;
    rsp_ready = 1'b0; tb_hready = 1'b1; force_fail = 1'b0; err_read = 1'b0;
    intrude = 1'b0; intr_idx = '0; intr_val = '0;
    #1;
    test_reset();
    test_fetch_add();
    test_cas();
    test_retry_collision();
    test_retry_exhaust();
    test_bus_error();
    test_wait_states();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
